// File: rtl/sobel_pkg.sv
// Shared Sobel pipeline definitions: the pixel type and default image geometry.
package sobel_pkg;

  localparam int PIX_W     = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of storage, addressed by column.
// The read is combinational and returns the old contents during a write cycle.
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign dout = mem[addr];

  // Write the incoming byte; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_window.sv
// 3x3 neighbourhood generator ahead of the Sobel gradient stage.
// Two chained line buffers supply the two previous lines, and a 3-column shift register
// forms the window. Only fully interior centres are strobed out.
module sobel_window
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pix_i,
  input  logic       pix_valid_i,
  input  logic       sof_i,
  output logic [7:0] d0_o,
  output logic [7:0] d1_o,
  output logic [7:0] d2_o,
  output logic [7:0] d3_o,
  output logic [7:0] d4_o,
  output logic [7:0] d5_o,
  output logic [7:0] d6_o,
  output logic [7:0] d7_o,
  output logic [7:0] d8_o,
  output logic       win_valid_o,
  output logic       done_o,
  output logic       busy_o
);

  logic [COL_W-1:0] col_q, col_d, col_cur;
  logic [ROW_W-1:0] row_q, row_d, row_cur;
  logic             last_col, last_row;
  pix_t             win_q [9];
  pix_t             win_d [9];
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  pix_t             tap1, tap2;

  // Line r-1 buffer: stores the current pixel, hands the old byte to the next buffer.
  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk  (clk),
    .we   (pix_valid_i),
    .addr (col_cur),
    .din  (pix_i),
    .dout (tap1)
  );

  // Line r-2 buffer, fed by the byte just displaced from line r-1.
  sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk  (clk),
    .we   (pix_valid_i),
    .addr (col_cur),
    .din  (tap1),
    .dout (tap2)
  );

  // Position of the pixel on the input, counter advance, window shift and strobes.
  always_comb begin
    col_cur  = sof_i ? '0 : col_q;
    row_cur  = sof_i ? '0 : row_q;
    last_col = (col_cur == COL_W'(IMG_W - 1));
    last_row = (row_cur == ROW_W'(IMG_H - 1));
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    vld_d    = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    if (pix_valid_i) begin
      col_d = last_col ? '0 : col_cur + 1'b1;
      if (last_col) row_d = last_row ? '0 : row_cur + 1'b1;
      else          row_d = row_cur;
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = tap2;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = tap1;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = pix_i;
      vld_d    = (row_cur >= ROW_W'(2)) && (col_cur >= COL_W'(2));
      done_d   = last_col && last_row;
      busy_d   = 1'b1;
    end else if (done_q) begin
      busy_d = 1'b0;
    end
  end

  // Control and window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      busy_q <= busy_d;
      win_q  <= win_d;
    end
  end

  assign d0_o        = win_q[0];
  assign d1_o        = win_q[1];
  assign d2_o        = win_q[2];
  assign d3_o        = win_q[3];
  assign d4_o        = win_q[4];
  assign d5_o        = win_q[5];
  assign d6_o        = win_q[6];
  assign d7_o        = win_q[7];
  assign d8_o        = win_q[8];
  assign win_valid_o = vld_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/sobel_window.md
Name: sobel_window

Overview:
- Upstream neighbour of the Sobel gradient stage. Accepts a raster-order 8-bit grayscale pixel stream.
- Holds the two previous image lines in circular line buffers and presents every fully-interior 3x3 neighbourhood as nine registered bytes d0..d8 with a window strobe.
- Raises a one-cycle done with the last window of each frame. The gradient stage consumes d0..d8 and done directly.

Parameters:
- IMG_W, 640, image width in pixels (>=3)
- IMG_H, 480, image height in lines (>=3)
- COL_W, $clog2(IMG_W), column counter width
- ROW_W, $clog2(IMG_H), row counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pix_i  in  8  grayscale pixel
- pix_valid_i  in  1  pix_i valid this cycle; no backpressure, every valid pixel is accepted
- sof_i  in  1  qualified by pix_valid_i; marks pixel (0,0) of a frame
- d0_o..d8_o  out  8 each  window: d0 d1 d2 = line r-1, d3 d4 d5 = line r, d6 d7 d8 = line r+1; left to right = columns c-1, c, c+1
- win_valid_o  out  1  d0_o..d8_o hold a valid window this cycle
- done_o  out  1  one-cycle pulse coincident with the last window of a frame
- busy_o  out  1  high from first accepted pixel of a frame until done_o

Behaviour:
- Reset (rst_n low, async): col/row counters = 0, window registers = 0, win_valid_o = 0, done_o = 0, busy_o = 0. Line-buffer RAM contents are not reset.
- Reset deassertion mid-frame: the next frame starts at the next pixel with sof_i, or at counter (0,0). No done_o is produced for the aborted frame.
- Counters:
  - An accepted pixel has position (row, col).
  - col increments per accepted pixel and wraps IMG_W-1 -> 0; row increments on that wrap.
  - After (IMG_H-1, IMG_W-1) both return to 0 (back-to-back frames, no idle cycle needed).
  - pix_valid_i && sof_i forces this pixel to (0,0) and counting continues from there, so a mid-frame sof aborts the current frame with no done_o.
  - Cycles with pix_valid_i low change nothing; all outputs except the two strobes hold.
- Line buffers:
  - Two IMG_W x 8 circular buffers, addressed by col. Reads are combinational with read-before-write semantics.
  - On an accepted pixel: tap1 = lb1[col] (line row-1), tap2 = lb2[col] (line row-2). Then lb1[col] <= pix_i and lb2[col] <= tap1.
- Column shift (per accepted pixel): d0<=d1, d1<=d2, d2<=tap2; d3<=d4, d4<=d5, d5<=tap1; d6<=d7, d7<=d8, d8<=pix_i.
- Window strobe:
  - win_valid_o <= 1 on the cycle after an accepted pixel with row>=2 && col>=2; otherwise 0.
  - Each strobe presents the window centred on (row-1, col-1). Border centres are never emitted.
  - Windows per frame = (IMG_W-2)*(IMG_H-2).
  - Stale column data across line wrap and stale RAM data across frames are always masked by this condition.
- Latency: 1 clk from accepting the bottom-right pixel to win_valid_o.
- done_o <= 1 on the cycle after accepting pixel (IMG_H-1, IMG_W-1), together with that window's win_valid_o.
- busy_o:
  - Set on the cycle after the first accepted pixel of a frame.
  - Cleared with done_o; set again if the next frame's pixel is accepted in that same cycle.
- Arithmetic: counters are unsigned; the comparisons against IMG_W-1 and IMG_H-1 are exact-width. No pixel arithmetic is performed in this block.

Decomposition:
- Shared package sobel_pkg: PIX_W = 8, the pixel typedef, and default IMG_W / IMG_H constants. These are also used by the gradient stage.
- One sub-module: sobel_line_buffer.
  - Parameters: DEPTH, WIDTH.
  - Ports: clk, we, addr, din, dout; combinational dout = mem[addr] before write.
  - Instantiated twice and chained: lb2's din is lb1's dout.
- Counters, shift registers and strobes stay in sobel_window.

Test Plan:
- Basic window:
  - Stimulus: IMG_W=5, IMG_H=4, pixel value = row*16+col, continuous valid.
  - Required: first win_valid_o one cycle after pixel (2,2) is accepted, with d0..d8 = 00 01 02 10 11 12 20 21 22 (hex).
  - Required: exactly 6 windows total.
- Frame end:
  - Stimulus: same frame as Basic window.
  - Required: the last window is 12 13 14 22 23 24 32 33 34 with done_o = 1 in the same cycle.
  - Required: done_o is asserted exactly once; busy_o falls after it.
- Valid gaps:
  - Stimulus: same frame with pix_valid_i randomly low for 0-3 cycles.
  - Required: identical window sequence and values; outputs hold during gaps.
- Back-to-back frames:
  - Stimulus: two 5x4 frames, the second with values +0x80, no idle cycle between.
  - Required: the second frame's first window = 80 81 82 90 91 92 A0 A1 A2, with no stale data.
  - Required: done_o is asserted twice.
- Mid-frame sof:
  - Stimulus: sof_i asserted at pixel (2,1) of frame 1.
  - Required: no done_o for frame 1; the new frame produces its 6 windows from its own rows only.
- Async reset:
  - Stimulus: rst_n pulled low mid-frame between clock edges.
  - Required: win_valid_o, done_o and busy_o go 0 immediately (without waiting for a clock edge).
  - Required: the next full frame after release yields 6 correct windows.
